// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost test-status responder: register offsets,
// STATUS bit positions and the completion state enum.
package tohost_pkg;

  localparam logic [3:0] TOHOST_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CYCLES_OFS = 4'h8;

  localparam int ST_RUN_BIT     = 0;
  localparam int ST_DONE_BIT    = 1;
  localparam int ST_PASS_BIT    = 2;
  localparam int ST_FAIL_BIT    = 3;
  localparam int ST_TIMEOUT_BIT = 4;

  localparam logic [31:0] TOHOST_PASS = 32'h1;

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} tohost_state_e;

  function automatic logic [31:0] status_word(input tohost_state_e s);
    logic [31:0] w;
    w                 = '0;
    w[ST_RUN_BIT]     = (s == RUN);
    w[ST_DONE_BIT]    = (s != RUN);
    w[ST_PASS_BIT]    = (s == PASS);
    w[ST_FAIL_BIT]    = (s == FAIL);
    w[ST_TIMEOUT_BIT] = (s == TIMEOUT);
    return w;
  endfunction

endpackage

// File: rtl/tohost_monitor_bus_slave_resp.sv
// Single-outstanding bus slave handshake: accept a request, register its response one
// cycle later and hold it until consumed; a new accept is allowed in the consuming cycle.
module bus_slave_resp #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  output logic          accept_o,
  input  logic [DW-1:0] rdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o
);

  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept_o    = req_valid_i && req_ready_o;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept_o) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rdata_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Bus slave decoding riscv-tests tohost stores into pass/fail/timeout status with a
// cycle counter and watchdog; responses one cycle after accept, held until rsp_ready.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_num,
  output logic [31:0] cycles
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  tohost_state_e state_q, state_d;
  logic [31:0]   tohost_q, tohost_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [30:0]   fail_num_q, fail_num_d;

  logic          accept;
  logic          in_range;
  logic [3:0]    ofs;
  logic [31:0]   rd_word;
  logic          tohost_wr;
  logic          wd_expire;
  logic          unused_addr_bits;

  assign in_range         = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs              = {req_addr[3:2], 2'b00};
  assign unused_addr_bits = ^req_addr[1:0];

  bus_slave_resp #(.DW(32)) u_resp (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .accept_o    (accept),
    .rdata_i     (rd_word),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata)
  );

  // Read data reflects state before any same-cycle write takes effect.
  always_comb begin
    rd_word = '0;
    if (!req_we && in_range) begin
      case (ofs)
        TOHOST_OFS: rd_word = tohost_q;
        STATUS_OFS: rd_word = status_word(state_q);
        CYCLES_OFS: rd_word = cycles_q;
        default:    rd_word = '0;
      endcase
    end
  end

  assign tohost_wr = accept && req_we && in_range && (ofs == TOHOST_OFS) && (req_wstrb == 4'hF);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (cycles_q == WD_LAST);

  always_comb begin
    state_d    = state_q;
    tohost_d   = tohost_q;
    cycles_d   = cycles_q;
    fail_num_d = fail_num_q;
    if (tohost_wr) tohost_d = req_wdata;
    case (state_q)
      RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        // A decisive tohost write outranks watchdog expiry in the same cycle.
        if (tohost_wr && (req_wdata == TOHOST_PASS)) begin
          state_d = PASS;
        end else if (tohost_wr && req_wdata[0]) begin
          state_d    = FAIL;
          fail_num_d = req_wdata[31:1];
        end else if (wd_expire) begin
          state_d = TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      tohost_q   <= '0;
      cycles_q   <= '0;
      fail_num_q <= '0;
    end else begin
      state_q    <= state_d;
      tohost_q   <= tohost_d;
      cycles_q   <= cycles_d;
      fail_num_q <= fail_num_d;
    end
  end

  assign done     = (state_q != RUN);
  assign pass     = (state_q == PASS);
  assign timeout  = (state_q == TIMEOUT);
  assign fail_num = fail_num_q;
  assign cycles   = cycles_q;

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Memory-mapped test-status responder on the core's data bus: receives the store that riscv-tests programs (rv32ui-p-*) issue to `tohost` and decodes it into pass/fail/test-number. Also runs a cycle counter with watchdog timeout. This moves test completion detection into hardware instead of PC/register probing. Sits beside data memory as a bus slave. Its status outputs drive benches, and later an FPGA LED/UART reporter.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: byte address of register block; 16-byte aligned.
- `TIMEOUT_CYCLES`, default 6000: watchdog limit in RUN; 0 disables watchdog.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `req_valid` in 1: bus request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables.
- `rsp_valid` out 1: response/ack for accepted request.
- `rsp_ready` in 1: core consumes response.
- `rsp_rdata` out 32: read data; 0 for writes.
- `done` out 1: state is PASS, FAIL or TIMEOUT.
- `pass` out 1: state is PASS.
- `timeout` out 1: state is TIMEOUT.
- `fail_num` out 31: failing test number, i.e. tohost value >> 1; 0 unless FAIL.
- `cycles` out 32: cycle count.

## Operation
- Register map (offset from BASE_ADDR, word addressed, `req_addr[1:0]` ignored):
  - +0 TOHOST, R/W.
  - +4 STATUS, RO: {27'b0, timeout, fail, pass, done, run}.
  - +8 CYCLES, RO.
  - +C, RO: reads 0.
- Addresses outside BASE_ADDR..BASE_ADDR+15: still acknowledged, with read data 0 and no side effects. Address decode is the upstream interconnect's job.
- States: RUN (reset), PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- TOHOST write in RUN, `req_wstrb == 4'hF` only:
  - value 0: ignored.
  - value 1: go to PASS.
  - odd value > 1: go to FAIL, `fail_num` <= value[31:1].
  - even nonzero value: no state change.
- TOHOST register latches every full-word write in any state. Partial-strobe writes are acknowledged and change nothing.
- Writes to RO offsets are acknowledged and ignored.
- `cycles` increments every cycle in RUN, saturates at 32'hFFFF_FFFF, and freezes on leaving RUN.
- Watchdog: in RUN with `TIMEOUT_CYCLES != 0`, when `cycles == TIMEOUT_CYCLES - 1` the next state is TIMEOUT.
- Simultaneous decisive TOHOST write and watchdog expiry in the same cycle: the write wins (PASS/FAIL).

## Timing
- Reset values:
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
  - `done` = `pass` = `timeout` = 0, `fail_num` = 0, `cycles` = 0, TOHOST = 0, state RUN.
- One outstanding request. Accept in cycle N; `rsp_valid` = 1 in cycle N+1 with `rsp_rdata` registered.
- `rsp_valid`/`rsp_rdata` hold stable until `rsp_ready`.
- `req_ready` = !`rsp_valid` | `rsp_ready`, so back-to-back accepts give one response per cycle when `rsp_ready` is held high.
- Write side effects (TOHOST, state, `fail_num`) are visible on outputs in cycle N+1.
- Reads return the pre-write value of the same cycle's state.
- Status outputs (`done`, `pass`, `timeout`, `fail_num`, `cycles`) are registered; no combinational path from bus inputs.
- Reset asserted mid-transaction: the pending response is dropped and all state returns to reset values asynchronously. First accept is possible in the first cycle after `rst` rises.

## Structure
- Shared package `tohost_pkg`:
  - register offsets: `TOHOST_OFS`, `STATUS_OFS`, `CYCLES_OFS`.
  - STATUS bit positions.
  - state enum {RUN, PASS, FAIL, TIMEOUT}.
  - constant `TOHOST_PASS` = 32'h1.
- Single module. The bus slave handshake (accept/hold response) is natural as sub-module `bus_slave_resp`, reused later by other MMIO devices.

## Test plan
- Reset, idle 10 cycles, then read +8 → `rsp_rdata` = 10 ± handshake offset (exact value checked against accept cycle); `done` = 0.
- Full-word write 1 to BASE+0 → next cycle `done` = `pass` = 1, `fail_num` = 0; read +4 → 32'h6; `cycles` frozen.
- Write 32'h0000_0007 → FAIL, `fail_num` = 3, STATUS = 32'hA. A later write of 1 → state unchanged, TOHOST reads 1.
- Write 1 with `req_wstrb` = 4'h1, then write 2 → both acknowledged, state RUN, TOHOST = 2.
- TIMEOUT_CYCLES = 20, no writes → `timeout` = `done` = 1 after `cycles` = 19. Same test with a write of 1 in the expiry cycle → PASS.
- Hold `rsp_ready` = 0 for 3 cycles after a read → `rsp_valid`/`rsp_rdata` stable and `req_ready` = 0. Drop `rst` mid-hold → all outputs at reset values immediately.
